// File: rtl/time_date_counter_if.sv
// Calendar-stage bus: day-carry and set-date requests in, current date and pulses out.
// master drives requests (hour stage / set-time path); slave is the calendar counter.
interface time_date_counter_if #(
  parameter int YEAR_W = 7
);
  logic              cout_day;
  logic              set_date_en;
  logic [4:0]        set_day;
  logic [3:0]        set_month;
  logic [YEAR_W-1:0] set_year;
  logic [2:0]        set_wday;
  logic [4:0]        out_day;
  logic [3:0]        out_month;
  logic [YEAR_W-1:0] out_year;
  logic [2:0]        out_wday;
  logic              cout_year;
  logic              set_err;

  // Request signals are single-cycle qualifiers: the counter samples them on every
  // clk edge, with no ready/back-pressure; the load request takes priority over cout_day.
  modport master (
    output cout_day, set_date_en, set_day, set_month, set_year, set_wday,
    input  out_day, out_month, out_year, out_wday, cout_year, set_err
  );

  modport slave (
    input  cout_day, set_date_en, set_day, set_month, set_year, set_wday,
    output out_day, out_month, out_year, out_wday, cout_year, set_err
  );
endinterface

// File: rtl/time_date_counter.sv
// Day/month/year (2000-2099 as offset) and day-of-week counter driven by the hour
// stage's day-carry, with a validated synchronous date load and a year-carry pulse.
module time_date_counter #(
   parameter int         YEAR_W   = 7,
   parameter logic [2:0] RST_WDAY = 3'd6
) (
   input  logic                 clk,
   input  logic                 rst,
   time_date_counter_if.slave   bus
);

   localparam logic [YEAR_W-1:0] YEAR_MAX = YEAR_W'(99);

   logic [4:0]        day_q,   day_n;
   logic [3:0]        month_q, month_n;
   logic [YEAR_W-1:0] year_q,  year_n;
   logic [2:0]        wday_q,  wday_n;
   logic              cout_year_q, cout_year_n;
   logic              set_err_q,   set_err_n;
   logic [4:0]        cur_dim;
   logic [4:0]        set_dim;
   logic              load_ok;

   // Year offsets share 2000's leap phase, so year[1:0]==0 is exact across the century.
   function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                input logic [YEAR_W-1:0] y);
      logic [4:0] d;
      case (m)
         4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
         4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 d = 5'd31;
      endcase
      return d;
   endfunction

   assign cur_dim = days_in_month(month_q, year_q);
   assign set_dim = days_in_month(bus.set_month, bus.set_year);

   assign load_ok = (bus.set_month >= 4'd1) && (bus.set_month <= 4'd12) &&
                    (bus.set_day >= 5'd1)   && (bus.set_day <= set_dim)   &&
                    (bus.set_year <= YEAR_MAX) && (bus.set_wday <= 3'd6);

   always_comb begin
      day_n       = day_q;
      month_n     = month_q;
      year_n      = year_q;
      wday_n      = wday_q;
      cout_year_n = 1'b0;
      set_err_n   = 1'b0;
      if (bus.set_date_en) begin
         // A load, valid or not, swallows any day-carry arriving in the same cycle.
         if (load_ok) begin
            day_n   = bus.set_day;
            month_n = bus.set_month;
            year_n  = bus.set_year;
            wday_n  = bus.set_wday;
         end else begin
            set_err_n = 1'b1;
         end
      end else if (bus.cout_day) begin
         wday_n = (wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1;
         if (day_q < cur_dim) begin
            day_n = day_q + 5'd1;
         end else begin
            day_n = 5'd1;
            if (month_q < 4'd12) begin
               month_n = month_q + 4'd1;
            end else begin
               month_n     = 4'd1;
               year_n      = (year_q >= YEAR_MAX) ? '0 : year_q + YEAR_W'(1);
               cout_year_n = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         day_q       <= 5'd1;
         month_q     <= 4'd1;
         year_q      <= '0;
         wday_q      <= RST_WDAY;
         cout_year_q <= 1'b0;
         set_err_q   <= 1'b0;
      end else begin
         day_q       <= day_n;
         month_q     <= month_n;
         year_q      <= year_n;
         wday_q      <= wday_n;
         cout_year_q <= cout_year_n;
         set_err_q   <= set_err_n;
      end
   end

   assign bus.out_day   = day_q;
   assign bus.out_month = month_q;
   assign bus.out_year  = year_q;
   assign bus.out_wday  = wday_q;
   assign bus.cout_year = cout_year_q;
   assign bus.set_err   = set_err_q;

endmodule
